pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the MIPS fetch stage; replaces the bare PC register.
//  Adds synchronous reset, stall, branch/jump redirect and call/return via a return-address stack (RAS).
//  Drives the instruction-memory address; control inputs come from decode/branch logic.
// PARAMETERS
//  ADDR_W      16      PC / target width in bits
//  INST_BYTES  2       PC increment per instruction (power of 2)
//  RESET_PC    16'h0   PC value loaded on reset
//  RAS_DEPTH   4       return-address stack entries (power of 2, >=2)
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       synchronous, active-high reset
//  stall          in   1       hold PC and RAS this cycle
//  branch_taken   in   1       redirect to branch_target
//  branch_target  in   ADDR_W  branch destination
//  jump           in   1       redirect to jump_target
//  call           in   1       jump to jump_target and push return address
//  ret            in   1       pop RAS into PC
//  jump_target    in   ADDR_W  jump/call destination
//  pc             out  ADDR_W  current instruction address (registered)
//  pc_next_seq    out  ADDR_W  pc + INST_BYTES (combinational)
//  ras_empty      out  1       RAS holds no entries
//  ras_full       out  1       RAS holds RAS_DEPTH entries
//  err            out  1       sticky: RAS overflow/underflow or call&ret collision
// BEHAVIOUR
//  - Reset: pc=RESET_PC, RAS count=0, ras_empty=1, ras_full=0, err=0. rst beats every other input.
//  - All updates on rising clk edge; redirect inputs sampled in cycle N, new pc visible in cycle N+1.
//  - Next-PC priority (no stall): ret > call > jump > branch_taken > sequential (pc+INST_BYTES).
//  - stall=1: pc, RAS contents/pointer and err all hold; every redirect input in that cycle is ignored.
//  - call: pc<=jump_target; push pc+INST_BYTES. If full: push overwrites oldest entry
//    (circular pointer wraps), count stays RAS_DEPTH, err<=1.
//  - ret: if not empty, pc<=top entry, count-1. If empty: pc<=pc+INST_BYTES, err<=1.
//  - call&ret same cycle: ret executed, call ignored (no push), err<=1.
//  - Arithmetic modulo 2^ADDR_W: pc = 2^ADDR_W-INST_BYTES wraps to 0, no flag.
//  - All targets and popped values have low log2(INST_BYTES) bits forced to 0.
//  - err clears only on rst.
//  - Reset mid-sequence discards all RAS entries; the following ret underflows.
//  - RAS is a LIFO: top pointer + count; read of top is combinational from the register array.
// STRUCTURE
//  - mips_pkg: ADDR_W, INST_BYTES, RESET_PC defaults; next-PC select encoding
//    (SEL_SEQ, SEL_BR, SEL_JMP, SEL_RET).
//  - Sub-module pc_ras (RAS_DEPTH x ADDR_W LIFO, push/pop/full/empty/overflow/underflow).
//  - pc_unit: priority mux, aligned target masking, pc register, err flag.
// TESTING
//  1 rst=1 two cycles, then 5 free cycles -> pc = 0,0,2,4,6,8,A; ras_empty=1; err=0.
//  2 pc=0x0010, branch_taken=1, target=0x0041 -> next pc=0x0040; same cycle with jump=1,
//    target=0x0100 -> pc=0x0100 (jump beats branch).
//  3 pc=0x0020 call target=0x0200, then at 0x0204 call 0x0300, ret, ret
//    -> pc 0x0300, then 0x0206, then 0x0022; ras_empty=1; err=0.
//  4 five calls with RAS_DEPTH=4 -> ras_full=1 and err=1 after the 5th;
//    four rets return the 4 newest addresses, 5th ret -> pc+2, err stays 1.
//  5 stall=1 for 3 cycles with call asserted -> pc and RAS unchanged; stall=0 -> call executes once.
//  6 pc=0xFFFE sequential -> pc=0x0000; rst mid-call-chain -> pc=RESET_PC, ras_empty=1, err=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared defaults and next-PC select encoding for the MIPS fetch-stage PC unit.
package mips_pkg;

  localparam int                DEF_ADDR_W     = 16;
  localparam int                DEF_INST_BYTES = 2;
  localparam logic [15:0]       DEF_RESET_PC   = 16'h0000;
  localparam int                DEF_RAS_DEPTH  = 4;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_JMP = 2'd2,
    SEL_RET = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular LIFO with top pointer and occupancy count.
// A push into a full stack overwrites the oldest entry; a pop from empty changes nothing.
module pc_ras
  import mips_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top_data,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              do_push_s, do_pop_s;

  assign empty     = (cnt_q == (PTR_W+1)'(0));
  assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
  assign top_data  = mem_q[ptr_q];
  assign do_push_s = push & ~pop;
  assign do_pop_s  = pop & ~push;
  assign overflow  = do_push_s & full;
  assign underflow = do_pop_s & empty;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (do_push_s) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (full) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + (PTR_W+1)'(1);
      end
    end else if (do_pop_s && !empty) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - (PTR_W+1)'(1);
    end else begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PTR_W'(0);
      cnt_q <= (PTR_W+1)'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ADDR_W'(0);
      end
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (do_push_s) begin
        mem_q[ptr_d] <= push_data;
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: stall, branch/jump redirect and call/return via a RAS.
// Priority without stall is ret > call > jump > branch > sequential; err is sticky until rst.
module pc_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                INST_BYTES = DEF_INST_BYTES,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
  parameter int                RAS_DEPTH  = DEF_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INST_BYTES) - ADDR_W'(1));

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;
  pc_sel_e           sel_s;
  logic              push_s, pop_s, collide_s;
  logic [ADDR_W-1:0] ras_top_s;
  logic              ras_ovf_s, ras_udf_s;

  assign pc_next_seq = pc_q + ADDR_W'(INST_BYTES);
  assign pc          = pc_q;
  assign err         = err_q;
  assign collide_s   = ret & call;

  // Stall freezes the stack, so push/pop only reach it when the PC advances.
  always_comb begin
    sel_s  = SEL_SEQ;
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (ret) begin
      pop_s = ~stall;
      if (ras_empty) begin
        sel_s = SEL_SEQ;
      end else begin
        sel_s = SEL_RET;
      end
    end else if (call) begin
      sel_s  = SEL_JMP;
      push_s = ~stall;
    end else if (jump) begin
      sel_s = SEL_JMP;
    end else if (branch_taken) begin
      sel_s = SEL_BR;
    end else begin
      sel_s = SEL_SEQ;
    end
  end

  always_comb begin
    pc_d = pc_next_seq;
    case (sel_s)
      SEL_SEQ: pc_d = pc_next_seq;
      SEL_BR:  pc_d = branch_target & ALIGN_MASK;
      SEL_JMP: pc_d = jump_target & ALIGN_MASK;
      SEL_RET: pc_d = ras_top_s & ALIGN_MASK;
      default: pc_d = pc_next_seq;
    endcase
    err_d = err_q | ras_ovf_s | ras_udf_s | collide_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else if (!stall) begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end else begin
      pc_q  <= pc_q;
      err_q <= err_q;
    end
  end

  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_next_seq),
    .top_data  (ras_top_s),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_ovf_s),
    .underflow (ras_udf_s)
  );

endmodule
